// File: rtl/key_sw_conditioner_pkg.sv
// Shared constants and debouncer state encoding for the key/switch conditioner.
package key_sw_conditioner_pkg;

  localparam int NUM_KEYS         = 4;
  localparam int NUM_SW           = 10;
  localparam int NUM_BITS         = NUM_KEYS + NUM_SW;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  // Per-bit debouncer states.
  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/key_sw_conditioner_debounce_bit.sv
// One raw input bit: synchronizer chain, optional inversion, and a
// STABLE/COUNTING debouncer with its own counter and registered level.
module debounce_bit
  import key_sw_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  // Active-low inputs reset to "released" (1) so the inverted level starts at 0.
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sync_lvl;

  // Synchronizer shift: raw enters at bit 0, the oldest stage feeds the debouncer.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Debounce decision. Entering COUNTING already counts the first differing
  // cycle, so the level flips after exactly DEBOUNCE_CYCLES differing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (sync_lvl != level_q) begin
          state_d = DB_COUNTING;
          cnt_d   = CNT_ONE;
        end
      end
      DB_COUNTING: begin
        if (sync_lvl == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = sync_lvl;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronizer, FSM, counter and output level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= SYNC_RST;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/key_sw_conditioner.sv
// Pushbutton/slider conditioner: 14 independent debouncers, press and change
// pulses, sticky press capture with write-one-to-clear, and a masked irq.
module key_sw_conditioner
  import key_sw_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_KEYS-1:0] edge_clr,
  input  logic [NUM_KEYS-1:0] irq_mask,
  output logic [NUM_KEYS-1:0] pushbuttons,
  output logic [NUM_SW-1:0]   switches,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                sw_change,
  output logic [NUM_KEYS-1:0] edge_capture,
  output logic                irq
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 2..2^24");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range 2..4");
  end

  // Keys occupy the low bits, switches the high bits.
  logic [NUM_BITS-1:0] raw_all;
  logic [NUM_BITS-1:0] lvl_all;

  assign raw_all = {SW, KEY};

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (i < NUM_KEYS)
    ) u_db (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .raw_in  (raw_all[i]),
      .level_o (lvl_all[i])
    );
  end

  logic [NUM_BITS-1:0] lvl_prev_q, lvl_prev_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic                sw_change_q, sw_change_d;
  logic [NUM_KEYS-1:0] edge_capture_q, edge_capture_d;
  logic                irq_q, irq_d;

  // Pulses come from comparing the debounced levels with last cycle's copy;
  // a new press wins over a simultaneous clear of the same capture bit.
  always_comb begin
    lvl_prev_d     = lvl_all;
    key_press_d    = lvl_all[NUM_KEYS-1:0] & ~lvl_prev_q[NUM_KEYS-1:0];
    sw_change_d    = |(lvl_all[NUM_BITS-1:NUM_KEYS] ^ lvl_prev_q[NUM_BITS-1:NUM_KEYS]);
    edge_capture_d = (edge_capture_q & ~edge_clr) | key_press_q;
    irq_d          = |(edge_capture_q & irq_mask);
  end

  // Event, capture and interrupt registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      lvl_prev_q     <= '0;
      key_press_q    <= '0;
      sw_change_q    <= 1'b0;
      edge_capture_q <= '0;
      irq_q          <= 1'b0;
    end else begin
      lvl_prev_q     <= lvl_prev_d;
      key_press_q    <= key_press_d;
      sw_change_q    <= sw_change_d;
      edge_capture_q <= edge_capture_d;
      irq_q          <= irq_d;
    end
  end

  assign pushbuttons  = lvl_all[NUM_KEYS-1:0];
  assign switches     = lvl_all[NUM_BITS-1:NUM_KEYS];
  assign key_press    = key_press_q;
  assign sw_change    = sw_change_q;
  assign edge_capture = edge_capture_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Bench for key_sw_conditioner: a window-based reference model checks every
// cycle, a vector table covers steady-state behaviour, and hand sequences
// cover latency, bounce, clear/press collision, reset mid-count and masking.
module tb_key_sw_conditioner;
  import key_sw_conditioner_pkg::*;

  localparam int DB = 8;
  localparam int SS = 2;
  localparam int HL = DB + SS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [3:0] KEY, edge_clr, irq_mask;
  logic [9:0] SW;
  logic [3:0] pushbuttons, key_press, edge_capture;
  logic [9:0] switches;
  logic       sw_change, irq;

  key_sw_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .KEY          (KEY),
    .SW           (SW),
    .edge_clr     (edge_clr),
    .irq_mask     (irq_mask),
    .pushbuttons  (pushbuttons),
    .switches     (switches),
    .key_press    (key_press),
    .sw_change    (sw_change),
    .edge_capture (edge_capture),
    .irq          (irq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a bit's level flips once the last DB synchronized
  // observations all disagree with it; observation at edge n is the
  // active-high input level present SS edges earlier.
  logic [13:0] hist[$];
  logic [13:0] m_db, m_db1;
  logic [3:0]  m_kp, m_ecap;
  logic        m_swc, m_irq;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < HL; i++) hist.push_back(14'h0);
    m_db = '0; m_db1 = '0; m_kp = '0; m_ecap = '0; m_swc = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    logic [13:0] nxt;
    logic        all_diff;
    if (!reset_n) return;
    hist.push_back({SW, ~KEY});
    void'(hist.pop_front());
    nxt = m_db;
    for (int b = 0; b < 14; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) if (hist[j][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nxt[b] = ~m_db[b];
    end
    m_irq  = |(m_ecap & irq_mask);
    m_ecap = (m_ecap & ~edge_clr) | m_kp;
    m_kp   = m_db[3:0] & ~m_db1[3:0];
    m_swc  = |(m_db[13:4] ^ m_db1[13:4]);
    m_db1  = m_db;
    m_db   = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pushbuttons"},  16'(pushbuttons),  16'(m_db[3:0]));
    chk({tag, ".switches"},     16'(switches),     16'(m_db[13:4]));
    chk({tag, ".key_press"},    16'(key_press),    16'(m_kp));
    chk({tag, ".sw_change"},    16'(sw_change),    16'(m_swc));
    chk({tag, ".edge_capture"}, 16'(edge_capture), 16'(m_ecap));
    chk({tag, ".irq"},          16'(irq),          16'(m_irq));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all("model");
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  typedef struct {
    logic [3:0] key;
    logic [9:0] sw;
    logic [3:0] clr;
    logic [3:0] mask;
    int         hold;
    logic [3:0] pb;
    logic [9:0] swo;
    logic [3:0] ecap;
    logic       irq;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1);
  end

  initial begin
    int sw_ev, kp_t, kp_cnt, sw_cnt;

    tbl[0] = '{4'hF, 10'h000, 4'h0, 4'h0, 12, 4'h0, 10'h000, 4'h0, 1'b0};
    tbl[1] = '{4'hF, 10'h3FF, 4'h0, 4'h0, 12, 4'h0, 10'h3FF, 4'h0, 1'b0};
    tbl[2] = '{4'hE, 10'h3FF, 4'h0, 4'h0, 12, 4'h1, 10'h3FF, 4'h1, 1'b0};
    tbl[3] = '{4'hE, 10'h3FF, 4'h0, 4'h1,  2, 4'h1, 10'h3FF, 4'h1, 1'b1};
    tbl[4] = '{4'hE, 10'h3FF, 4'h1, 4'h1,  1, 4'h1, 10'h3FF, 4'h0, 1'b1};
    tbl[5] = '{4'hE, 10'h3FF, 4'h0, 4'h1,  1, 4'h1, 10'h3FF, 4'h0, 1'b0};
    tbl[6] = '{4'hF, 10'h000, 4'h0, 4'h0, 12, 4'h0, 10'h000, 4'h0, 1'b0};
    tbl[7] = '{4'hF, 10'h001, 4'h0, 4'h0,  7, 4'h0, 10'h000, 4'h0, 1'b0};
    tbl[8] = '{4'hF, 10'h000, 4'h0, 4'h0, 12, 4'h0, 10'h000, 4'h0, 1'b0};

    // Reset state
    KEY = 4'hF; SW = '0; edge_clr = '0; irq_mask = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    ticks(2);
    reset_n = 1'b1;

    // Vector table
    for (int v = 0; v < 9; v++) begin
      KEY = tbl[v].key; SW = tbl[v].sw; edge_clr = tbl[v].clr; irq_mask = tbl[v].mask;
      ticks(tbl[v].hold);
      chk($sformatf("tbl%0d.pushbuttons", v),  16'(pushbuttons),  16'(tbl[v].pb));
      chk($sformatf("tbl%0d.switches", v),     16'(switches),     16'(tbl[v].swo));
      chk($sformatf("tbl%0d.edge_capture", v), 16'(edge_capture), 16'(tbl[v].ecap));
      chk($sformatf("tbl%0d.irq", v),          16'(irq),          16'(tbl[v].irq));
    end
    edge_clr = '0; irq_mask = '0;

    // KEY[0] press latency
    KEY = 4'hE;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 9)  chk("key0_pb_early", 16'(pushbuttons[0]), 16'h0);
      if (t == 10) chk("key0_pb_at10", 16'(pushbuttons[0]), 16'h1);
      if (t == 10) chk("key0_kp_at10", 16'(key_press), 16'h0);
      if (t == 11) chk("key0_kp_at11", 16'(key_press), 16'h1);
      if (t == 12) chk("key0_kp_at12", 16'(key_press), 16'h0);
      if (t == 12) chk("key0_ecap", 16'(edge_capture[0]), 16'h1);
    end
    KEY = 4'hF; ticks(12);
    edge_clr = 4'hF; tick(); edge_clr = '0;

    // SW[5] short glitch never surfaces
    SW = 10'h020; ticks(5); SW = '0;
    sw_ev = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (sw_change || switches != 10'h0) sw_ev++;
    end
    chk("sw5_glitch_events", 16'(sw_ev), 16'h0);

    // KEY[2] bounce then hold
    KEY = 4'hB; ticks(3); KEY = 4'hF; ticks(3);
    KEY = 4'hB; ticks(3); KEY = 4'hF; ticks(3);
    KEY = 4'hB;
    kp_t = 0; kp_cnt = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 9)  chk("key2_pb_early", 16'(pushbuttons[2]), 16'h0);
      if (t == 10) chk("key2_pb_at10", 16'(pushbuttons[2]), 16'h1);
      if (key_press[2]) begin kp_cnt++; kp_t = t; end
    end
    chk("key2_kp_count", 16'(kp_cnt), 16'h1);
    chk("key2_kp_time", 16'(kp_t), 16'd11);
    KEY = 4'hF; ticks(12);

    // Clear colliding with a new press; irq masking
    edge_clr = 4'hF; tick(); edge_clr = '0;
    KEY = 4'hD; ticks(12);
    chk("key1_first_capture", 16'(edge_capture[1]), 16'h1);
    KEY = 4'hF; ticks(12);
    KEY = 4'hD; ticks(11);
    chk("key1_second_kp", 16'(key_press[1]), 16'h1);
    edge_clr = 4'h2; tick(); edge_clr = '0;
    chk("key1_set_wins_clear", 16'(edge_capture[1]), 16'h1);
    irq_mask = 4'h2; tick();
    chk("irq_masked_on", 16'(irq), 16'h1);
    irq_mask = 4'h0; tick();
    chk("irq_masked_off", 16'(irq), 16'h0);
    chk("ecap_kept_when_masked", 16'(edge_capture[1]), 16'h1);

    // Reset mid-count with SW[9] and KEY[1] held
    SW = 10'h200; ticks(7);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pushbuttons", 16'(pushbuttons), 16'h0);
    chk("rst_switches", 16'(switches), 16'h0);
    chk("rst_edge_capture", 16'(edge_capture), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    check_all("reset_mid");
    ticks(2);
    reset_n = 1'b1;
    sw_cnt = 0; kp_cnt = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 9)  chk("sw9_early", 16'(switches[9]), 16'h0);
      if (t == 10) chk("sw9_at10", 16'(switches[9]), 16'h1);
      if (t == 11) chk("sw9_change_at11", 16'(sw_change), 16'h1);
      if (sw_change) sw_cnt++;
      if (key_press[1]) kp_cnt++;
    end
    chk("sw9_change_count", 16'(sw_cnt), 16'h1);
    chk("key1_after_reset_count", 16'(kp_cnt), 16'h1);

    // All keys at once
    KEY = 4'hF; SW = '0; ticks(12);
    edge_clr = 4'hF; tick(); edge_clr = '0;
    irq_mask = 4'hF;
    KEY = 4'h0;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 11) chk("all_keys_kp", 16'(key_press), 16'hF);
      if (t == 12) chk("all_keys_irq_early", 16'(irq), 16'h0);
      if (t == 13) chk("all_keys_irq", 16'(irq), 16'h1);
    end
    KEY = 4'hF; irq_mask = '0; ticks(12);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)  if ($urandom_range(19) == 0) KEY[b] = ~KEY[b];
      for (int b = 0; b < 10; b++) if ($urandom_range(19) == 0) SW[b] = ~SW[b];
      edge_clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(15) == 0) irq_mask = 4'($urandom);
      if ($urandom_range(299) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("rand_reset");
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
